// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state and arbiter state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive data grants taken while an ifetch was waiting.
module arb_starve_counter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    assign sat = (count == CNT_W'(STARVE_MAX));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single-ported RAM between instruction fetch and data access,
// holding each registered access stable until the RAM reports completion.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  ramstate_t         ramstate
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t        state, next_state;
    logic [WORD_W-1:0] lat_addr, lat_store;
    logic              grant_d, grant_i;
    logic              starve_sat;
    logic [CNT_W-1:0]  starve_cnt;

    // A data grant only counts as starvation when an ifetch was also waiting.
    arb_starve_counter #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_starve (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (grant_d && iREN),
        .clr   ((grant_d && !iREN) || grant_i),
        .count (starve_cnt),
        .sat   (starve_sat)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_store <= '0;
        end else begin
            state <= next_state;
            if (grant_d) begin
                lat_addr  <= daddr;
                lat_store <= dstore;
            end else if (grant_i) begin
                lat_addr  <= iaddr;
            end
        end
    end

    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            IDLE: begin
                if ((dREN || dWEN) && !(iREN && starve_sat)) begin
                    grant_d    = 1'b1;
                    next_state = dWEN ? DWRITE : DREAD;
                end else if (iREN) begin
                    grant_i    = 1'b1;
                    next_state = IFETCH;
                end
            end
            IFETCH, DREAD, DWRITE: begin
                if (ramstate == ACCESS) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Enables decode straight from state so an async reset drops them at once.
    always_comb begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
        iwait  = 1'b1;
        dwait  = 1'b1;
        case (state)
            IFETCH: begin
                ramREN = 1'b1;
                if (ramstate == ACCESS) iwait = 1'b0;
            end
            DREAD: begin
                ramREN = 1'b1;
                if (ramstate == ACCESS) dwait = 1'b0;
            end
            DWRITE: begin
                ramWEN = 1'b1;
                if (ramstate == ACCESS) dwait = 1'b0;
            end
            default: ;
        endcase
    end

    assign ramaddr  = lat_addr;
    assign ramstore = lat_store;
    assign iload    = ramload;
    assign dload    = ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a queue of expected RAM accesses.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    typedef struct {
        logic  data;
        logic  wr;
        word_t addr;
        word_t store;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 CLK = ~CLK;

    memory_arbiter #(
        .WORD_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    function automatic word_t ram_model(word_t a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign ramload = ram_model(ramaddr);

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_i(word_t a);
        sb.push_back('{data: 1'b0, wr: 1'b0, addr: a, store: '0});
    endtask

    task automatic push_d(logic w, word_t a, word_t s);
        sb.push_back('{data: 1'b1, wr: w, addr: a, store: s});
    endtask

    task automatic check_bus(exp_t e);
        check("ram_ren", ramREN, !e.wr);
        check("ram_wen", ramWEN, e.wr);
        check("ram_addr", ramaddr, e.addr);
        if (e.wr) check("ram_store", ramstore, e.store);
        check("waits_not_both_low", iwait | dwait, 1);
    endtask

    // Plays the RAM for one access already granted: BUSY, ERROR, then ACCESS.
    task automatic serve(int unsigned busy, int unsigned errs);
        exp_t e;
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        repeat (busy) begin
            ramstate = BUSY;
            #1;
            check_bus(e);
            check("busy_iwait", iwait, 1);
            check("busy_dwait", dwait, 1);
            step();
        end
        repeat (errs) begin
            ramstate = ERROR;
            #1;
            check_bus(e);
            check("err_iwait", iwait, 1);
            check("err_dwait", dwait, 1);
            step();
        end
        ramstate = ACCESS;
        #1;
        check_bus(e);
        check("hit_iwait", iwait, e.data ? 1 : 0);
        check("hit_dwait", dwait, e.data ? 0 : 1);
        if (!e.data) check("iload", iload, ram_model(e.addr));
        if (e.data && !e.wr) check("dload", dload, ram_model(e.addr));
        step();
        ramstate = FREE;
        #1;
        check("done_ren", ramREN, 0);
        check("done_wen", ramWEN, 0);
        check("done_iwait", iwait, 1);
        check("done_dwait", dwait, 1);
        check("done_state", 32'(dut.state), 32'(DONE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramstate = FREE;
        #3;
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_ren", ramREN, 0);
        check("rst_wen", ramWEN, 0);
        check("rst_addr", ramaddr, 0);
        check("rst_store", ramstore, 0);
        check("rst_starve", 32'(dut.u_starve.count), 0);
        step();
        step();
        nRST = 1'b1;

        // Single instruction fetch, RAM latency 2.
        iREN = 1'b1; iaddr = 32'h0000_0040; push_i(32'h0000_0040);
        step();
        serve(1, 0);
        iREN = 1'b0;
        step();
        check("t1_idle", 32'(dut.state), 32'(IDLE));

        // Simultaneous requests: data wins first, then the fetch.
        iREN = 1'b1; iaddr = 32'h0000_0080; dREN = 1'b1; daddr = 32'h0000_0100;
        push_d(1'b0, 32'h0000_0100, '0);
        push_i(32'h0000_0080);
        step();
        check("t2_first_dread", 32'(dut.state), 32'(DREAD));
        serve(1, 0);
        dREN = 1'b0;
        step();
        step();
        check("t2_then_ifetch", 32'(dut.state), 32'(IFETCH));
        serve(1, 0);
        iREN = 1'b0;
        step();

        // Continuous writes starve the fetch for exactly STARVE_MAX grants.
        iREN = 1'b1; iaddr = 32'h0000_0300; dWEN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            daddr  = 32'h0000_0400 + 32'(k * 4);
            dstore = 32'h1111_0000 + 32'(k);
            push_d(1'b1, daddr, dstore);
            step();
            check("t3_dwrite", 32'(dut.state), 32'(DWRITE));
            check("t3_starve", 32'(dut.u_starve.count), 32'(k + 1));
            serve(1, 0);
            step();
        end
        push_i(32'h0000_0300);
        step();
        check("t3_ifetch", 32'(dut.state), 32'(IFETCH));
        check("t3_starve_clr", 32'(dut.u_starve.count), 0);
        serve(1, 0);
        iREN = 1'b0; dWEN = 1'b0;
        step();

        // RAM errors during a write: access re-issued unchanged.
        dWEN = 1'b1; daddr = 32'h0000_0200; dstore = 32'hDEAD_BEEF;
        push_d(1'b1, 32'h0000_0200, 32'hDEAD_BEEF);
        step();
        serve(1, 3);
        dWEN = 1'b0;
        step();

        // Asynchronous reset in the middle of a read.
        dREN = 1'b1; daddr = 32'h0000_0500;
        step();
        ramstate = BUSY;
        #1;
        check("t5_ren_before", ramREN, 1);
        #1;
        nRST = 1'b0;
        #1;
        check("t5_ren_abort", ramREN, 0);
        check("t5_state", 32'(dut.state), 32'(IDLE));
        check("t5_iwait", iwait, 1);
        check("t5_dwait", dwait, 1);
        dREN = 1'b0; ramstate = FREE;
        #2;
        nRST = 1'b1;
        step();
        iREN = 1'b1; iaddr = 32'h0000_0600; push_i(32'h0000_0600);
        step();
        check("t5_ifetch", 32'(dut.state), 32'(IFETCH));
        serve(1, 0);
        iREN = 1'b0;
        step();

        // Address changes and request drops mid-access are ignored.
        dREN = 1'b1; daddr = 32'h0000_0700; push_d(1'b0, 32'h0000_0700, '0);
        step();
        daddr = 32'h0000_07FC; ramstate = BUSY;
        #1;
        check("t6_addr_held", ramaddr, 32'h0000_0700);
        step();
        dREN = 1'b0;
        serve(1, 0);
        step();
        check("t6_idle", 32'(dut.state), 32'(IDLE));
        check("t6_ren", ramREN, 0);
        step();
        check("t6_stay_idle", 32'(dut.state), 32'(IDLE));

        check("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
